// File: rtl/ex_div_pkg.sv
// Shared opcode, result-class and divider-state definitions for the MIPS32 execute stage.
package ex_div_pkg;

  localparam int RegBus     = 32;
  localparam int RegAddrBus = 5;
  localparam int AluOpBus   = 8;
  localparam int AluSelBus  = 3;

  localparam logic [AluOpBus-1:0] EXE_NOP_OP  = 8'b00000000;
  localparam logic [AluOpBus-1:0] EXE_AND_OP  = 8'b00100100;
  localparam logic [AluOpBus-1:0] EXE_OR_OP   = 8'b00100101;
  localparam logic [AluOpBus-1:0] EXE_XOR_OP  = 8'b00100110;
  localparam logic [AluOpBus-1:0] EXE_NOR_OP  = 8'b00100111;
  localparam logic [AluOpBus-1:0] EXE_SLL_OP  = 8'b01111100;
  localparam logic [AluOpBus-1:0] EXE_SRL_OP  = 8'b00000010;
  localparam logic [AluOpBus-1:0] EXE_SRA_OP  = 8'b00000011;
  localparam logic [AluOpBus-1:0] EXE_SLT_OP  = 8'b00101010;
  localparam logic [AluOpBus-1:0] EXE_SLTU_OP = 8'b00101011;
  localparam logic [AluOpBus-1:0] EXE_ADDU_OP = 8'b00100001;
  localparam logic [AluOpBus-1:0] EXE_SUBU_OP = 8'b00100011;
  localparam logic [AluOpBus-1:0] EXE_MFHI_OP = 8'b00010000;
  localparam logic [AluOpBus-1:0] EXE_MTHI_OP = 8'b00010001;
  localparam logic [AluOpBus-1:0] EXE_MFLO_OP = 8'b00010010;
  localparam logic [AluOpBus-1:0] EXE_MTLO_OP = 8'b00010011;
  localparam logic [AluOpBus-1:0] EXE_DIV_OP  = 8'b00011010;
  localparam logic [AluOpBus-1:0] EXE_DIVU_OP = 8'b00011011;

  localparam logic [AluSelBus-1:0] EXE_RES_NOP        = 3'b000;
  localparam logic [AluSelBus-1:0] EXE_RES_LOGIC      = 3'b001;
  localparam logic [AluSelBus-1:0] EXE_RES_SHIFT      = 3'b010;
  localparam logic [AluSelBus-1:0] EXE_RES_MOVE       = 3'b011;
  localparam logic [AluSelBus-1:0] EXE_RES_ARITHMETIC = 3'b100;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'b00,
    DIV_BUSY = 2'b01,
    DIV_DONE = 2'b10
  } div_state_e;

  function automatic logic is_div(input logic [AluOpBus-1:0] op);
    return (op == EXE_DIV_OP) || (op == EXE_DIVU_OP);
  endfunction

endpackage

// File: rtl/ex_div_div_unit.sv
// 32-step restoring divider on operand magnitudes; signs are re-applied while in DONE.
module div_unit
  import ex_div_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        signed_div,
  input  logic [31:0] opdata1,
  input  logic [31:0] opdata2,
  input  logic        annul,
  output logic [63:0] result,
  output logic        ready,
  output div_state_e  state_o
);

  div_state_e  state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [63:0] pr_q, pr_d;
  logic [31:0] divisor_q, divisor_d;
  logic        neg_quo_q, neg_quo_d;
  logic        neg_rem_q, neg_rem_d;

  logic [31:0] a_mag, b_mag;
  logic [64:0] shifted;
  logic [32:0] diff;
  logic [63:0] step;
  logic [31:0] quo, rem;

  always_comb begin
    a_mag   = (signed_div && opdata1[31]) ? -opdata1 : opdata1;
    b_mag   = (signed_div && opdata2[31]) ? -opdata2 : opdata2;
    shifted = {pr_q, 1'b0};
    diff    = shifted[64:32] - {1'b0, divisor_q};
    // Negative trial difference means the divisor did not fit: keep the shifted value, quotient bit 0.
    step    = diff[32] ? shifted[63:0] : {diff[31:0], shifted[31:1], 1'b1};

    state_d   = state_q;
    cnt_d     = cnt_q;
    pr_d      = pr_q;
    divisor_d = divisor_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;

    case (state_q)
      DIV_IDLE: begin
        if (start) begin
          cnt_d = 6'd0;
          if (opdata2 == 32'd0) begin
            pr_d      = {opdata1, 32'hFFFF_FFFF};
            neg_quo_d = 1'b0;
            neg_rem_d = 1'b0;
            state_d   = DIV_DONE;
          end else begin
            pr_d      = {32'd0, a_mag};
            divisor_d = b_mag;
            neg_quo_d = signed_div & (opdata1[31] ^ opdata2[31]);
            neg_rem_d = signed_div & opdata1[31];
            state_d   = DIV_BUSY;
          end
        end
      end
      DIV_BUSY: begin
        pr_d  = step;
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) state_d = DIV_DONE;
      end
      DIV_DONE: state_d = DIV_IDLE;
      default:  state_d = DIV_IDLE;
    endcase

    if (annul) begin
      state_d = DIV_IDLE;
      cnt_d   = 6'd0;
    end

    quo     = neg_quo_q ? -pr_q[31:0]  : pr_q[31:0];
    rem     = neg_rem_q ? -pr_q[63:32] : pr_q[63:32];
    result  = {rem, quo};
    ready   = (state_q == DIV_DONE) && !annul;
    state_o = state_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= DIV_IDLE;
      cnt_q     <= 6'd0;
      pr_q      <= 64'd0;
      divisor_q <= 32'd0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pr_q      <= pr_d;
      divisor_q <= divisor_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
    end
  end

endmodule

// File: rtl/ex_div.sv
// MIPS32 execute stage: logic/shift/arith/move results, HI/LO ownership and the iterative divider.
module ex_div
  import ex_div_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [AluOpBus-1:0]   aluop_i,
  input  logic [AluSelBus-1:0]  alusel_i,
  input  logic [RegBus-1:0]     reg1_i,
  input  logic [RegBus-1:0]     reg2_i,
  input  logic [RegAddrBus-1:0] wd_i,
  input  logic                  wreg_i,
  input  logic                  annul_i,
  output logic [RegAddrBus-1:0] wd_o,
  output logic                  wreg_o,
  output logic [RegBus-1:0]     wdata_o,
  output logic                  stallreq_o
);

  logic [RegBus-1:0]    hi_q, hi_d, lo_q, lo_d;
  logic [RegBus-1:0]    res;
  logic [AluSelBus-1:0] op_class;
  logic                 res_valid;
  logic                 div_op, div_start, div_ready;
  logic [63:0]          div_result;
  div_state_e           div_state;

  assign div_op    = is_div(aluop_i);
  assign div_start = div_op & ~annul_i;

  div_unit u_div (
    .clk        (clk),
    .rst        (rst),
    .start      (div_start),
    .signed_div (aluop_i == EXE_DIV_OP),
    .opdata1    (reg1_i),
    .opdata2    (reg2_i),
    .annul      (annul_i),
    .result     (div_result),
    .ready      (div_ready),
    .state_o    (div_state)
  );

  // A result is produced only when alusel names the class the opcode belongs to.
  always_comb begin
    res      = '0;
    op_class = EXE_RES_NOP;
    case (aluop_i)
      EXE_OR_OP:   begin res = reg1_i | reg2_i;    op_class = EXE_RES_LOGIC; end
      EXE_AND_OP:  begin res = reg1_i & reg2_i;    op_class = EXE_RES_LOGIC; end
      EXE_XOR_OP:  begin res = reg1_i ^ reg2_i;    op_class = EXE_RES_LOGIC; end
      EXE_NOR_OP:  begin res = ~(reg1_i | reg2_i); op_class = EXE_RES_LOGIC; end
      EXE_SLL_OP:  begin res = reg2_i << reg1_i[4:0];  op_class = EXE_RES_SHIFT; end
      EXE_SRL_OP:  begin res = reg2_i >> reg1_i[4:0];  op_class = EXE_RES_SHIFT; end
      EXE_SRA_OP:  begin res = $signed(reg2_i) >>> reg1_i[4:0]; op_class = EXE_RES_SHIFT; end
      EXE_ADDU_OP: begin res = reg1_i + reg2_i; op_class = EXE_RES_ARITHMETIC; end
      EXE_SUBU_OP: begin res = reg1_i - reg2_i; op_class = EXE_RES_ARITHMETIC; end
      EXE_SLT_OP:  begin
        res      = {31'd0, $signed(reg1_i) < $signed(reg2_i)};
        op_class = EXE_RES_ARITHMETIC;
      end
      EXE_SLTU_OP: begin res = {31'd0, reg1_i < reg2_i}; op_class = EXE_RES_ARITHMETIC; end
      EXE_MFHI_OP: begin res = hi_q; op_class = EXE_RES_MOVE; end
      EXE_MFLO_OP: begin res = lo_q; op_class = EXE_RES_MOVE; end
      default: ;
    endcase
    res_valid = (op_class != EXE_RES_NOP) && (op_class == alusel_i);
  end

  always_comb begin
    wd_o       = '0;
    wreg_o     = 1'b0;
    wdata_o    = '0;
    stallreq_o = 1'b0;
    if (!rst) begin
      wd_o       = wd_i;
      wreg_o     = wreg_i & res_valid;
      wdata_o    = res_valid ? res : '0;
      stallreq_o = div_op && !annul_i && (div_state != DIV_DONE);
    end
  end

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (aluop_i == EXE_MTHI_OP) hi_d = reg1_i;
    if (aluop_i == EXE_MTLO_OP) lo_d = reg1_i;
    if (div_ready) begin
      hi_d = div_result[63:32];
      lo_d = div_result[31:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

endmodule

// File: tb/tb_ex_div.sv
// Bench for ex_div: directed and random instructions scored against a plain-arithmetic model of the stage.
module tb_ex_div;
  import ex_div_pkg::*;

  logic        clk, rst;
  logic [7:0]  aluop_i;
  logic [2:0]  alusel_i;
  logic [31:0] reg1_i, reg2_i;
  logic [4:0]  wd_i;
  logic        wreg_i, annul_i;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic        stallreq_o;

  ex_div dut (
    .clk(clk), .rst(rst), .aluop_i(aluop_i), .alusel_i(alusel_i),
    .reg1_i(reg1_i), .reg2_i(reg2_i), .wd_i(wd_i), .wreg_i(wreg_i),
    .annul_i(annul_i), .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
    .stallreq_o(stallreq_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout act=running req=finished");
    $fatal(1, "timeout");
  end

  int          n_total = 0;
  int          n_pass  = 0;
  bit          mon_en  = 1'b0;
  logic [37:0] exp_q[$];
  string       name_q[$];
  logic [31:0] hi_m = 32'd0;
  logic [31:0] lo_m = 32'd0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s act=%0h req=%0h", nm, act, req);
  endtask

  function automatic logic [2:0] class_of(input logic [7:0] op);
    case (op)
      EXE_OR_OP, EXE_AND_OP, EXE_XOR_OP, EXE_NOR_OP: return EXE_RES_LOGIC;
      EXE_SLL_OP, EXE_SRL_OP, EXE_SRA_OP:            return EXE_RES_SHIFT;
      EXE_ADDU_OP, EXE_SUBU_OP, EXE_SLT_OP, EXE_SLTU_OP: return EXE_RES_ARITHMETIC;
      EXE_MFHI_OP, EXE_MFLO_OP:                      return EXE_RES_MOVE;
      default:                                       return EXE_RES_NOP;
    endcase
  endfunction

  function automatic logic [31:0] model(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    int unsigned sh;
    sh = a % 32;
    case (op)
      EXE_OR_OP:   return a | b;
      EXE_AND_OP:  return a & b;
      EXE_XOR_OP:  return a ^ b;
      EXE_NOR_OP:  return ~(a | b);
      EXE_SLL_OP:  return b * (32'd1 << sh);
      EXE_SRL_OP:  return b / (33'd1 << sh);
      EXE_SRA_OP:  return (b >> sh) | (b[31] ? ~(32'hFFFF_FFFF >> sh) : 32'd0);
      EXE_ADDU_OP: return a + b;
      EXE_SUBU_OP: return a + ~b + 32'd1;
      EXE_SLT_OP:  return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      EXE_SLTU_OP: return (longint'(a) < longint'(b)) ? 32'd1 : 32'd0;
      EXE_MFHI_OP: return hi_m;
      EXE_MFLO_OP: return lo_m;
      default:     return 32'd0;
    endcase
  endfunction

  task automatic drive_nop();
    aluop_i = EXE_NOP_OP; alusel_i = EXE_RES_NOP;
    reg1_i = 32'd0; reg2_i = 32'd0; wd_i = 5'd0; wreg_i = 1'b0; annul_i = 1'b0;
  endtask

  // driver: present one instruction, hold it while stalled, annul at cycle annul_at if >= 0
  task automatic issue(input logic [7:0] op, input logic [2:0] sel, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] wd, input logic wreg,
                       input int annul_at, input string nm);
    logic        div_op, known, e_w;
    logic [31:0] e_d;
    int          stalls, c;
    longint      sa, sb, q, r;
    div_op = (op == EXE_DIV_OP) || (op == EXE_DIVU_OP);
    known  = (class_of(op) != EXE_RES_NOP) && (class_of(op) == sel);
    e_w    = wreg && known;
    e_d    = known ? model(op, a, b) : 32'd0;
    stalls = div_op ? ((b == 32'd0) ? 1 : 33) : 0;
    if (div_op && annul_at >= 0) stalls = annul_at;
    exp_q.push_back({wd, e_w, e_d});
    name_q.push_back(nm);
    aluop_i = op; alusel_i = sel; reg1_i = a; reg2_i = b; wd_i = wd; wreg_i = wreg; annul_i = 1'b0;
    for (c = 0; c < 100; c++) begin
      if (c == annul_at) annul_i = 1'b1;
      @(negedge clk);
      if (!stallreq_o) break;
      @(posedge clk); #1;
    end
    chk({nm, "_stall_cycles"}, 64'(c), 64'(stalls));
    if (op == EXE_MTHI_OP) hi_m = a;
    if (op == EXE_MTLO_OP) lo_m = a;
    if (div_op && annul_at < 0) begin
      if (b == 32'd0) begin
        lo_m = 32'hFFFF_FFFF; hi_m = a;
      end else if (op == EXE_DIVU_OP) begin
        lo_m = a / b; hi_m = a % b;
      end else begin
        sa = longint'($signed(a)); sb = longint'($signed(b));
        q = sa / sb; r = sa % sb;
        lo_m = q[31:0]; hi_m = r[31:0];
      end
    end
    @(posedge clk); #1;
    drive_nop();
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (mon_en && !rst && !stallreq_o && exp_q.size() > 0) begin
      logic [37:0] e;
      string       nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      chk(nm, {26'd0, wd_o, wreg_o, wdata_o}, {26'd0, e});
    end
  end

  task automatic check_reset_outputs(input string nm);
    chk({nm, "_wd"},    64'(wd_o),       64'd0);
    chk({nm, "_wreg"},  64'(wreg_o),     64'd0);
    chk({nm, "_wdata"}, 64'(wdata_o),    64'd0);
    chk({nm, "_stall"}, 64'(stallreq_o), 64'd0);
  endtask

  initial begin
    logic [7:0] ops [13];
    logic [7:0] op;
    int         c;
    ops = '{EXE_OR_OP, EXE_AND_OP, EXE_XOR_OP, EXE_NOR_OP, EXE_SLL_OP, EXE_SRL_OP, EXE_SRA_OP,
            EXE_ADDU_OP, EXE_SUBU_OP, EXE_SLT_OP, EXE_SLTU_OP, EXE_MFHI_OP, EXE_MFLO_OP};
    rst = 1'b1;
    drive_nop();
    aluop_i = EXE_OR_OP; alusel_i = EXE_RES_LOGIC; reg1_i = 32'h1234; reg2_i = 32'h8; wd_i = 5'd5; wreg_i = 1'b1;
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    drive_nop();
    rst = 1'b0;
    mon_en = 1'b1;

    issue(EXE_OR_OP,   EXE_RES_LOGIC,      32'h0000_1100, 32'h0000_0020, 5'd5, 1'b1, -1, "ori");
    issue(EXE_SRA_OP,  EXE_RES_SHIFT,      32'd4,         32'h8000_0010, 5'd6, 1'b1, -1, "sra");
    issue(EXE_SLT_OP,  EXE_RES_ARITHMETIC, 32'hFFFF_FFFF, 32'd1,         5'd7, 1'b1, -1, "slt");
    issue(EXE_SLTU_OP, EXE_RES_ARITHMETIC, 32'hFFFF_FFFF, 32'd1,         5'd8, 1'b1, -1, "sltu");
    issue(EXE_SUBU_OP, EXE_RES_ARITHMETIC, 32'd3,         32'd5,         5'd9, 1'b1, -1, "subu_wrap");
    issue(8'hFF,       EXE_RES_LOGIC,      32'hFFFF,      32'hFF00,      5'd3, 1'b1, -1, "unknown_op");
    issue(EXE_NOP_OP,  EXE_RES_NOP,        32'h5,         32'h6,         5'd4, 1'b1, -1, "nop");

    issue(EXE_DIVU_OP, EXE_RES_NOP,  32'd100, 32'd7, 5'd0, 1'b0, -1, "divu_100_7");
    issue(EXE_MFLO_OP, EXE_RES_MOVE, 32'd0,   32'd0, 5'd10, 1'b1, -1, "mflo_14");
    issue(EXE_MFHI_OP, EXE_RES_MOVE, 32'd0,   32'd0, 5'd11, 1'b1, -1, "mfhi_2");
    issue(EXE_DIV_OP,  EXE_RES_NOP,  32'hFFFF_FFF9, 32'd2, 5'd0, 1'b0, -1, "div_m7_2");
    issue(EXE_MFLO_OP, EXE_RES_MOVE, 32'd0, 32'd0, 5'd12, 1'b1, -1, "mflo_m3");
    issue(EXE_MFHI_OP, EXE_RES_MOVE, 32'd0, 32'd0, 5'd13, 1'b1, -1, "mfhi_m1");
    issue(EXE_DIV_OP,  EXE_RES_NOP,  32'h8000_0000, 32'hFFFF_FFFF, 5'd0, 1'b0, -1, "div_min_m1");
    issue(EXE_MFLO_OP, EXE_RES_MOVE, 32'd0, 32'd0, 5'd14, 1'b1, -1, "mflo_min");
    issue(EXE_MFHI_OP, EXE_RES_MOVE, 32'd0, 32'd0, 5'd15, 1'b1, -1, "mfhi_zero");
    issue(EXE_DIVU_OP, EXE_RES_NOP,  32'd5, 32'd0, 5'd0, 1'b0, -1, "divu_by_zero");
    issue(EXE_MFLO_OP, EXE_RES_MOVE, 32'd0, 32'd0, 5'd16, 1'b1, -1, "mflo_dz");
    issue(EXE_MFHI_OP, EXE_RES_MOVE, 32'd0, 32'd0, 5'd17, 1'b1, -1, "mfhi_dz");

    // annul mid-divide leaves HI/LO untouched
    issue(EXE_MTHI_OP, EXE_RES_NOP, 32'h1111_1111, 32'd0, 5'd1, 1'b1, -1, "mthi");
    issue(EXE_MTLO_OP, EXE_RES_NOP, 32'h2222_2222, 32'd0, 5'd2, 1'b1, -1, "mtlo");
    issue(EXE_DIVU_OP, EXE_RES_NOP, 32'd100, 32'd7, 5'd0, 1'b0, 10, "divu_annul10");
    issue(EXE_MFHI_OP, EXE_RES_MOVE, 32'd0, 32'd0, 5'd18, 1'b1, -1, "mfhi_after_annul");
    issue(EXE_MFLO_OP, EXE_RES_MOVE, 32'd0, 32'd0, 5'd19, 1'b1, -1, "mflo_after_annul");

    // reset at cycle 20 of a divide
    issue(EXE_MTHI_OP, EXE_RES_NOP, 32'h1111_1111, 32'd0, 5'd1, 1'b1, -1, "mthi2");
    issue(EXE_MTLO_OP, EXE_RES_NOP, 32'h2222_2222, 32'd0, 5'd2, 1'b1, -1, "mtlo2");
    mon_en = 1'b0;
    aluop_i = EXE_DIVU_OP; alusel_i = EXE_RES_NOP; reg1_i = 32'd100; reg2_i = 32'd7; wd_i = 5'd5; wreg_i = 1'b1;
    for (c = 0; c < 20; c++) begin
      @(negedge clk);
      if (!stallreq_o) break;
      @(posedge clk); #1;
    end
    chk("rst_div_stall_before", 64'(c), 64'd20);
    rst = 1'b1;
    aluop_i = EXE_OR_OP; alusel_i = EXE_RES_LOGIC; reg1_i = 32'hF0; reg2_i = 32'h0F;
    @(negedge clk);
    check_reset_outputs("mid_div_reset");
    @(posedge clk); #1;
    drive_nop();
    rst = 1'b0;
    hi_m = 32'd0; lo_m = 32'd0;
    mon_en = 1'b1;
    issue(EXE_MFHI_OP, EXE_RES_MOVE, 32'd0, 32'd0, 5'd20, 1'b1, -1, "mfhi_after_rst");
    issue(EXE_MFLO_OP, EXE_RES_MOVE, 32'd0, 32'd0, 5'd21, 1'b1, -1, "mflo_after_rst");

    // random mix
    for (int i = 0; i < 60; i++) begin
      logic [31:0] a, b;
      a = $urandom();
      b = $urandom();
      if ($urandom_range(0, 4) == 0) begin
        op = ($urandom_range(0, 1) == 0) ? EXE_DIV_OP : EXE_DIVU_OP;
        case ($urandom_range(0, 3))
          0: b = 32'd0;
          1: b = $urandom_range(1, 20);
          2: b = -$urandom_range(1, 20);
          default: ;
        endcase
        issue(op, EXE_RES_NOP, a, b, 5'($urandom_range(0, 31)), 1'b0, -1, "rnd_div");
      end else begin
        op = ops[$urandom_range(0, 12)];
        issue(op, class_of(op), a, b, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), -1, "rnd_op");
      end
    end

    repeat (3) @(negedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
